mdu_exec: RTL
=============

// Module: mdu_exec
// PURPOSE
//  Iterative multiply/divide unit beside the Execute-stage ALU. Owns the HI/LO pair and runs
//  MULT/MULTU/DIV/DIVU over multiple cycles, plus single-cycle MTHI/MTLO.
//  Asserts busy so the pipeline stalls MFHI/MFLO and further MDU ops until done.
// PARAMETERS
//  XLEN      32  operand / HI / LO width (even, >=8)
//  HILO_RST  0   reset value of HI and LO
// PORTS
//  clock     in   1     rising-edge clock
//  reset     in   1     synchronous, active-high
//  start     in   1     issue op (sampled only when busy=0)
//  op        in   4     MDU opcode, `MDU_OP_* from mdu.vh
//  rs_val    in   XLEN  multiplicand / dividend / MTHI-MTLO data
//  rt_val    in   XLEN  multiplier / divisor
//  flush     in   1     squash in-flight op (branch/exception kill)
//  busy      out  1     multi-cycle op in flight
//  done      out  1     one-cycle pulse, HI/LO updated this cycle
//  divz      out  1     with done: last op was divide by zero
//  hi        out  XLEN  HI register
//  lo        out  XLEN  LO register
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, divz=0, hi=lo=HILO_RST. Reset mid-op aborts; no done.
//  FSM: IDLE -> RUN (XLEN iterations, cnt 0..XLEN-1) -> FIX (1 cycle) -> IDLE.
//  IDLE + start + legal mul/div op: latch |operands| and signs, busy=1 next cycle.
//  RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle.
//  FIX: sign correction, write HI/LO, done=1 in the following cycle with busy=0.
//   Latency: done asserted XLEN+2 cycles after the start edge; back-to-back start accepted then.
//  MULT/MULTU: {HI,LO} = full 2*XLEN product, signed / unsigned.
//  DIV/DIVU: LO = quotient, HI = remainder; quotient truncates toward zero;
//   remainder takes the sign of rs_val.
//  Divide by zero: LO = all ones, HI = rs_val, divz=1 with done; full latency kept.
//  Signed overflow (MIN / -1): LO = MIN, HI = 0, divz=0.
//  MTHI/MTLO: IDLE only; HI/LO written at the start edge; no busy, no done.
//  start while busy: ignored (caller must stall). Illegal op: ignored, no state change.
//  flush: any state -> IDLE next edge; HI/LO unchanged; no done.
//   flush+start in the same cycle: flush wins, op not accepted.
//  hi/lo always show committed registers; never partial results.
// CONFIGURATION
//  MDU_MADD_EN defined: MADD/MADDU/MSUB/MSUBU legal.
//   {HI,LO} +/- product is applied in FIX, with the same latency as MULT.
//  Undefined: these four opcodes are illegal and ignored (busy stays 0).
// STRUCTURE
//  mdu.vh: `MDU_OP_MULT 4'b0000, _MULTU 0001, _DIV 0010, _DIVU 0011, _MTHI 0100, _MTLO 0101,
//   _MADD 1000, _MADDU 1001, _MSUB 1010, _MSUBU 1011; FSM state encodings.
//  Sub-module mdu_divider: unsigned restoring divider (one step per enable).
//  FSM, multiplier datapath, sign fix and HI/LO stay in mdu_exec.
// TESTING (XLEN=32)
//  MULT rs=0xFFFFFFFD, rt=7 -> done 34 cycles after start, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//  DIVU 100/7 -> LO=14, HI=2.
//   DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  DIV 5/0 -> LO=0xFFFFFFFF, HI=5, divz=1.
//   DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  DIV with flush at cycle 10 -> no done, HI/LO unchanged, busy=0 next cycle.
//   start while busy -> ignored.
//  MTLO 0x1234 then MULTU 0x10000*0x10000 -> lo=0x1234 next cycle, then HI=1, LO=0.
//   reset mid-op -> hi=lo=0.
//  MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1*1 -> HI=1, LO=0.
//   Without MDU_MADD_EN: busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_exec_pkg.sv
// mdu_exec_pkg: MDU opcodes, FSM states and op-class helpers; MDU_MADD_EN makes MADD/MADDU/MSUB/MSUBU legal
package mdu_exec_pkg;
   localparam logic [3:0] OP_MULT  = 4'b0000;
   localparam logic [3:0] OP_MULTU = 4'b0001;
   localparam logic [3:0] OP_DIV   = 4'b0010;
   localparam logic [3:0] OP_DIVU  = 4'b0011;
   localparam logic [3:0] OP_MTHI  = 4'b0100;
   localparam logic [3:0] OP_MTLO  = 4'b0101;
   localparam logic [3:0] OP_MADD  = 4'b1000;
   localparam logic [3:0] OP_MADDU = 4'b1001;
   localparam logic [3:0] OP_MSUB  = 4'b1010;
   localparam logic [3:0] OP_MSUBU = 4'b1011;
`ifdef MDU_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;
   function automatic logic is_mul(input logic [3:0] op);
      return op inside {OP_MULT, OP_MULTU} || (MADD_EN && op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU});
   endfunction
   function automatic logic is_div(input logic [3:0] op);
      return op inside {OP_DIV, OP_DIVU};
   endfunction
endpackage

// File: rtl/mdu_exec_if.sv
// mdu_exec_if: issue/result bus between the pipeline (master) and the MDU (slave)
//  master drives start/op/rs_val/rt_val/flush; slave returns busy/done/divz/hi/lo
interface mdu_exec_if #(parameter int XLEN = 32);
   logic start;
   logic flush;
   logic [3:0] op;
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;
   logic busy;
   logic done;
   logic divz;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   modport master (output start, flush, op, rs_val, rt_val, input busy, done, divz, hi, lo);
   modport slave (input start, flush, op, rs_val, rt_val, output busy, done, divz, hi, lo);
endinterface

// File: rtl/mdu_exec_divider.sv
// mdu_exec_divider: unsigned restoring divider, one quotient bit per step
//  load latches dividend/divisor; step shifts one bit; quotient/remainder valid after XLEN steps
module mdu_exec_divider #(parameter int XLEN = 32) (
   input logic clock,
   input logic load,
   input logic step,
   input logic [XLEN-1:0] dividend,
   input logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);
   logic [XLEN-1:0] den;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;
   assign shifted = {remainder, quotient[XLEN-1]};
   // msb of diff is the borrow: set means the trial subtract is undone
   assign diff = shifted - {1'b0, den};
   always_ff @(posedge clock) begin
      if (load) begin
         quotient <= dividend;
         remainder <= '0;
         den <= divisor;
      end else if (step) begin
         quotient <= {quotient[XLEN-2:0], ~diff[XLEN]};
         remainder <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      end
   end
endmodule

// File: rtl/mdu_exec.sv
// mdu_exec: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, single-cycle MTHI/MTLO; MDU_MADD_EN adds MADD/MSUB family
//  clock, reset (sync active-high); bus (slave): start/op/rs_val/rt_val/flush in, busy/done/divz/hi/lo out
module mdu_exec
   import mdu_exec_pkg::*;
#(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] HILO_RST = '0
) (
   input logic clock,
   input logic reset,
   mdu_exec_if.slave bus
);
   localparam int CW = $clog2(XLEN);
   state_t state;
   logic [CW-1:0] cnt;
   logic [3:0] op_q;
   logic [XLEN-1:0] rs_q;
   logic [XLEN-1:0] a_q;
   logic [2*XLEN-1:0] prod;
   logic neg_q;
   logic neg_r;
   logic zero_q;
   logic sgn;
   logic accept;
   logic [XLEN-1:0] abs_rs;
   logic [XLEN-1:0] abs_rt;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN:0] sum;
   logic [2*XLEN-1:0] prod_fix;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;
   assign sgn = ~bus.op[0];
   assign accept = state == S_IDLE && bus.start && !bus.flush && (is_mul(bus.op) || is_div(bus.op));
   assign abs_rs = (sgn && bus.rs_val[XLEN-1]) ? -bus.rs_val : bus.rs_val;
   assign abs_rt = (sgn && bus.rt_val[XLEN-1]) ? -bus.rt_val : bus.rt_val;
   // multiplier in the low half of prod is consumed lsb-first as the partial sum shifts in from the top
   assign sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_q} : '0);
   assign prod_fix = neg_q ? -prod : prod;
   assign quo_fix = neg_q ? -quo : quo;
   assign rem_fix = neg_r ? -rem : rem;
   assign acc = !(MADD_EN && op_q[3]) ? prod_fix :
                op_q[1] ? {bus.hi, bus.lo} - prod_fix : {bus.hi, bus.lo} + prod_fix;
   mdu_exec_divider #(.XLEN(XLEN)) u_div (
      .clock(clock),
      .load(accept),
      .step(state == S_RUN),
      .dividend(abs_rs),
      .divisor(abs_rt),
      .quotient(quo),
      .remainder(rem)
   );
   always_ff @(posedge clock) begin
      bus.done <= 1'b0;
      bus.divz <= 1'b0;
      if (reset) begin
         state <= S_IDLE;
         bus.busy <= 1'b0;
         bus.hi <= HILO_RST;
         bus.lo <= HILO_RST;
      end else if (bus.flush) begin
         state <= S_IDLE;
         bus.busy <= 1'b0;
      end else if (state == S_IDLE) begin
         if (accept) begin
            state <= S_RUN;
            bus.busy <= 1'b1;
            cnt <= '0;
            op_q <= bus.op;
            rs_q <= bus.rs_val;
            a_q <= abs_rs;
            prod <= {{XLEN{1'b0}}, abs_rt};
            neg_q <= sgn & (bus.rs_val[XLEN-1] ^ bus.rt_val[XLEN-1]);
            neg_r <= sgn & bus.rs_val[XLEN-1];
            zero_q <= bus.rt_val == '0;
         end else if (bus.start && bus.op == OP_MTHI)
            bus.hi <= bus.rs_val;
         else if (bus.start && bus.op == OP_MTLO)
            bus.lo <= bus.rs_val;
      end else if (state == S_RUN) begin
         cnt <= cnt + 1'b1;
         prod <= {sum, prod[XLEN-1:1]};
         if (cnt == CW'(XLEN - 1))
            state <= S_FIX;
      end else begin
         state <= S_IDLE;
         bus.busy <= 1'b0;
         bus.done <= 1'b1;
         if (is_div(op_q)) begin
            bus.divz <= zero_q;
            bus.lo <= zero_q ? '1 : quo_fix;
            bus.hi <= zero_q ? rs_q : rem_fix;
         end else begin
            bus.hi <= acc[2*XLEN-1:XLEN];
            bus.lo <= acc[XLEN-1:0];
         end
      end
   end
endmodule
